// File: rtl/tiw_pkg.sv
// Shared types for the CPU step/run controller: FSM state encoding and
// the STEP_MODE selector values.
package tiw_pkg;

  typedef enum logic [1:0] {
    ST_HALT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STEP_CYC = 2'd2,
    ST_STEP_INS = 2'd3
  } state_t;

  localparam logic STEP_MODE_CYC = 1'b0;
  localparam logic STEP_MODE_INS = 1'b1;

  function automatic state_t step_state(input logic mode);
    return (mode == STEP_MODE_INS) ? ST_STEP_INS : ST_STEP_CYC;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on a level request. It stays disarmed for the first
// clock after reset, so a level held high through reset release is not an edge.
module rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_o = armed_q & level_i & ~prev_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/halt/single-step controller producing a CPU clock enable from TICK,
// with an opcode-fetch breakpoint and a count of issued enables.
module cpu_step_ctrl
  import tiw_pkg::*;
#(
  parameter bit START_RUN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             TICK,
  input  logic             RUN_REQ,
  input  logic             HALT_REQ,
  input  logic             STEP_REQ,
  input  logic             STEP_MODE,
  input  logic             BP_EN,
  input  logic [15:0]      BP_ADDR,
  input  logic [15:0]      A,
  input  logic             SYNC,
  output logic             CPU_CE,
  output logic             HALTED,
  output logic             BP_HIT,
  output logic [CNT_W-1:0] CYCLES,
  output state_t           STATE_DBG
);

  localparam state_t RESET_STATE = START_RUN ? ST_RUN : ST_HALT;

  state_t           state_q, state_d;
  logic             bp_hit_q, bp_hit_d;
  logic             skip_q, skip_d;
  logic             halted_q;
  logic [CNT_W-1:0] cycles_q;
  logic             ce;
  logic             bp_match;
  logic             run_rise, halt_rise, step_rise;

  rise_detect u_run_rise  (.clk_i(CLK), .rst_ni(RESET_n), .level_i(RUN_REQ),  .rise_o(run_rise));
  rise_detect u_halt_rise (.clk_i(CLK), .rst_ni(RESET_n), .level_i(HALT_REQ), .rise_o(halt_rise));
  rise_detect u_step_rise (.clk_i(CLK), .rst_ni(RESET_n), .level_i(STEP_REQ), .rise_o(step_rise));

  // skip_q masks the breakpoint on the first fetch after resuming from HALT
  assign bp_match = TICK & SYNC & BP_EN & (A == BP_ADDR) & ~skip_q;

  always_comb begin
    state_d  = state_q;
    bp_hit_d = bp_hit_q;
    skip_d   = skip_q;
    ce       = 1'b0;
    if (halt_rise) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_HALT: begin
          if (run_rise) begin
            state_d  = ST_RUN;
            bp_hit_d = 1'b0;
            skip_d   = 1'b1;
          end else if (step_rise) begin
            state_d  = step_state(STEP_MODE);
            bp_hit_d = 1'b0;
            skip_d   = 1'b1;
          end
        end
        ST_RUN: begin
          if (bp_match) begin
            state_d  = ST_HALT;
            bp_hit_d = 1'b1;
          end else begin
            ce = TICK;
          end
        end
        ST_STEP_CYC: begin
          if (TICK) begin
            ce      = 1'b1;
            state_d = ST_HALT;
          end
        end
        ST_STEP_INS: begin
          // skip_q still set means no enable has been issued in this step yet
          if (TICK & SYNC & ~skip_q) begin
            state_d = ST_HALT;
            if (bp_match) bp_hit_d = 1'b1;
          end else begin
            ce = TICK;
          end
        end
        default: state_d = ST_HALT;
      endcase
    end
    if (ce) skip_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= RESET_STATE;
      bp_hit_q <= 1'b0;
      skip_q   <= 1'b0;
      halted_q <= (RESET_STATE == ST_HALT);
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      bp_hit_q <= bp_hit_d;
      skip_q   <= skip_d;
      halted_q <= (state_d == ST_HALT);
      cycles_q <= cycles_q + CNT_W'(ce);
    end
  end

  assign CPU_CE    = ce & RESET_n;
  assign HALTED    = halted_q;
  assign BP_HIT    = bp_hit_q;
  assign CYCLES    = cycles_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: one instance starting in RUN (16-bit counter) and
// one starting in HALT (4-bit counter) share all inputs.
module tb_cpu_step_ctrl;
  import tiw_pkg::*;

  logic        CLK, RESET_n, TICK, RUN_REQ, HALT_REQ, STEP_REQ, STEP_MODE, BP_EN, SYNC;
  logic [15:0] BP_ADDR, A;

  logic        ce1, halted1, bp1;
  logic [15:0] cyc1;
  state_t      st1;
  logic        ce4, halted4, bp4;
  logic [3:0]  cyc4;
  state_t      st4;

  cpu_step_ctrl #(.START_RUN(1'b1), .CNT_W(16)) u1 (
    .CLK(CLK), .RESET_n(RESET_n), .TICK(TICK), .RUN_REQ(RUN_REQ), .HALT_REQ(HALT_REQ),
    .STEP_REQ(STEP_REQ), .STEP_MODE(STEP_MODE), .BP_EN(BP_EN), .BP_ADDR(BP_ADDR), .A(A),
    .SYNC(SYNC), .CPU_CE(ce1), .HALTED(halted1), .BP_HIT(bp1), .CYCLES(cyc1), .STATE_DBG(st1)
  );

  cpu_step_ctrl #(.START_RUN(1'b0), .CNT_W(4)) u4 (
    .CLK(CLK), .RESET_n(RESET_n), .TICK(TICK), .RUN_REQ(RUN_REQ), .HALT_REQ(HALT_REQ),
    .STEP_REQ(STEP_REQ), .STEP_MODE(STEP_MODE), .BP_EN(BP_EN), .BP_ADDR(BP_ADDR), .A(A),
    .SYNC(SYNC), .CPU_CE(ce4), .HALTED(halted4), .BP_HIT(bp4), .CYCLES(cyc4), .STATE_DBG(st4)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int n_ce1 = 0;
  int n_ce4 = 0;
  logic ce1_s, ce4_s, t_ce1, t_ce4;
  logic [15:0] exp_q[$];

  always @(negedge CLK) begin
    if (ce1) n_ce1++;
    if (ce4) n_ce4++;
  end

  // scoreboard
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %h expected <empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // drivers
  task automatic step_clk();
    @(negedge CLK);
    ce1_s = ce1;
    ce4_s = ce4;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic tick_cyc(input logic s, input logic [15:0] addr);
    TICK = 1'b1;
    SYNC = s;
    A    = addr;
    step_clk();
    t_ce1 = ce1_s;
    t_ce4 = ce4_s;
    TICK = 1'b0;
    step_clk();
  endtask

  task automatic req_pulse(input int which);
    case (which)
      0: RUN_REQ  = 1'b1;
      1: HALT_REQ = 1'b1;
      default: STEP_REQ = 1'b1;
    endcase
    step_clk();
    RUN_REQ  = 1'b0;
    HALT_REQ = 1'b0;
    STEP_REQ = 1'b0;
    step_clk();
  endtask

  task automatic reset_dut(input logic run_lvl);
    RESET_n = 1'b0;
    TICK = 1'b1; RUN_REQ = run_lvl; HALT_REQ = 1'b0; STEP_REQ = 1'b0;
    STEP_MODE = STEP_MODE_CYC; BP_EN = 1'b0; BP_ADDR = 16'h0; A = 16'h0; SYNC = 1'b0;
    #2;
    push(0); pop_chk("ce1_in_reset", ce1);
    push(0); pop_chk("ce4_in_reset", ce4);
    step_clk();
    TICK = 1'b0;
    RESET_n = 1'b1;
    step_clk();
  endtask

  int base1, base4;
  logic [5:0] pat;

  initial begin
    RESET_n = 1'b0;
    @(posedge CLK); #1;

    // reset state, then free run with TICK every 4 CLK
    reset_dut(1'b0);
    push(0);            pop_chk("rst_cyc1", cyc1);
    push(0);            pop_chk("rst_halted1", halted1);
    push(0);            pop_chk("rst_bp1", bp1);
    push(16'(ST_RUN));  pop_chk("rst_st1", 16'(st1));
    push(1);            pop_chk("rst_halted4", halted4);
    push(0);            pop_chk("rst_cyc4", cyc4);
    base1 = n_ce1; base4 = n_ce4;
    for (int i = 0; i < 40; i++) begin
      TICK = (i % 4 == 0);
      step_clk();
    end
    TICK = 1'b0;
    push(10); pop_chk("run_ce_count", 16'(n_ce1 - base1));
    push(10); pop_chk("run_cycles", cyc1);
    push(0);  pop_chk("run_halted", halted1);
    push(0);  pop_chk("halt_inst_no_ce", 16'(n_ce4 - base4));

    // single-cycle step from HALT
    reset_dut(1'b0);
    base4 = n_ce4;
    STEP_MODE = STEP_MODE_CYC;
    req_pulse(2);
    push(0); pop_chk("stepc_busy", halted4);
    idle(2);
    for (int k = 0; k < 3; k++) tick_cyc(1'b0, 16'h0100);
    push(1); pop_chk("stepc_ce_count", 16'(n_ce4 - base4));
    push(1); pop_chk("stepc_halted", halted4);
    push(1); pop_chk("stepc_cycles", cyc4);

    // single-instruction step, SYNC on ticks 0 and 3
    reset_dut(1'b0);
    STEP_MODE = STEP_MODE_INS;
    req_pulse(2);
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      tick_cyc((k == 0) || (k == 3), 16'(16'h0200 + k));
      pat[k] = t_ce4;
    end
    push(16'h0007); pop_chk("stepi_pattern", 16'(pat));
    push(3);        pop_chk("stepi_cycles", cyc4);
    push(1);        pop_chk("stepi_halted", halted4);

    // breakpoint in RUN, resume executes the breakpoint fetch once
    reset_dut(1'b0);
    BP_EN = 1'b1; BP_ADDR = 16'hE000;
    tick_cyc(1'b1, 16'h1000);
    push(1); pop_chk("bp_pre_ce", t_ce1);
    tick_cyc(1'b1, 16'hE000);
    push(0); pop_chk("bp_ce", t_ce1);
    push(1); pop_chk("bp_hit", bp1);
    push(1); pop_chk("bp_halted", halted1);
    req_pulse(0);
    push(0); pop_chk("bp_clr", bp1);
    tick_cyc(1'b1, 16'hE000);
    push(1); pop_chk("bp_resume_ce", t_ce1);
    push(0); pop_chk("bp_resume_hit", bp1);
    tick_cyc(1'b0, 16'hE001);
    tick_cyc(1'b1, 16'hE000);
    push(0); pop_chk("bp_again_ce", t_ce1);
    push(1); pop_chk("bp_again_hit", bp1);

    // HALT_REQ and RUN_REQ rise together with TICK during RUN
    reset_dut(1'b0);
    tick_cyc(1'b0, 16'h3000);
    HALT_REQ = 1'b1; RUN_REQ = 1'b1; TICK = 1'b1;
    step_clk();
    push(0); pop_chk("halt_win_ce", ce1_s);
    TICK = 1'b0;
    step_clk();
    push(1); pop_chk("halt_win_halted", halted1);
    tick_cyc(1'b0, 16'h3001);
    push(0); pop_chk("halt_hold_ce", t_ce1);
    RUN_REQ = 1'b0; HALT_REQ = 1'b0;
    step_clk();

    // 4-bit counter wraps after 17 enables
    reset_dut(1'b0);
    base4 = n_ce4;
    req_pulse(0);
    for (int k = 0; k < 17; k++) tick_cyc($urandom_range(0, 1) == 1, 16'($urandom_range(0, 16'hFFFF)));
    req_pulse(1);
    push(17); pop_chk("wrap_ce_count", 16'(n_ce4 - base4));
    push(1);  pop_chk("wrap_cycles", cyc4);
    push(1);  pop_chk("wrap_halted", halted4);

    // request level held through reset release is not an edge
    reset_dut(1'b1);
    idle(3);
    tick_cyc(1'b0, 16'h0400);
    push(0);            pop_chk("lvl_no_ce", t_ce4);
    push(16'(ST_HALT)); pop_chk("lvl_state", 16'(st4));
    RUN_REQ = 1'b0;
    step_clk();

    // reset in the middle of an instruction step abandons it
    reset_dut(1'b0);
    base4 = n_ce4;
    STEP_MODE = STEP_MODE_INS;
    req_pulse(2);
    tick_cyc(1'b1, 16'h0500);
    push(1); pop_chk("mid_first_ce", t_ce4);
    RESET_n = 1'b0; TICK = 1'b1;
    step_clk();
    TICK = 1'b0; RESET_n = 1'b1;
    step_clk();
    for (int k = 0; k < 3; k++) tick_cyc(1'b0, 16'h0501);
    push(1); pop_chk("mid_ce_count", 16'(n_ce4 - base4));
    push(0); pop_chk("mid_cycles", cyc4);
    push(1); pop_chk("mid_halted", halted4);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
